sram_controller: RTL and testbench



---
 rtl/sram_controller_pkg.sv | 36 +++
 rtl/sram_controller.sv | 197 +++++++++++++++++++
 tb/tb_sram_controller.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_pkg.sv
// -----------------------------------------------------------------------------
// sram_controller_pkg
//   Shared types and constants for the asynchronous-SRAM bus slave:
//   chip word-address and byte-mask types, byte-mask constants, the RAM
//   window prefix, and the controller state encoding (exported so that
//   benches and debug logic can decode it).
// -----------------------------------------------------------------------------
package sram_controller_pkg;

    localparam int unsigned SRAM_DATA_WIDTH = 32;
    localparam int unsigned SRAM_ADDR_WIDTH = 20;

    // Upper address byte of the RAM window on the system bus.
    localparam logic [7:0] RAM_PREFIX = 8'h00;

    typedef logic [SRAM_ADDR_WIDTH-1:0] SramChipAddress_t;
    typedef logic [3:0]                 ByteMask_t;

    localparam ByteMask_t BYTE_MASK_NONE = 4'b0000;
    localparam ByteMask_t BYTE_MASK_ALL  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_DONE
    } SramState_t;

    // Bus byte address -> SRAM word address (byte_addr[21:2]).
    function automatic SramChipAddress_t word_addr(input logic [31:0] byte_addr);
        return SramChipAddress_t'(byte_addr >> 2);
    endfunction

endpackage

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//   Bus slave that turns single-word read/write requests into timed
//   asynchronous-SRAM cycles, holding the master with stall_o until each
//   cycle is complete.
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     address_i           bus byte address (word address = address_i[21:2])
//     read_i, write_i     level requests, held until stall_o is seen low
//     data_wr_i, mask_i   write data and active-high byte enables
//     stall_o             combinational: request still in progress
//     data_rd_o           registered read data (valid when stall_o drops)
//     data_rd_2_o         tied 0
//     interrupt_o         tied 0
//     sram_address_o      SRAM word address
//     sram_data_out_o     data driven to SRAM, sram_data_oe_o enables the driver
//     sram_data_in_i      data returned by SRAM
//     sram_be_n_o         active-low byte enables
//     sram_ce_n_o, sram_oe_n_o, sram_we_n_o   active-low strobes
//
//   All SRAM-side outputs are registered: their next values are derived
//   from the next state, so each strobe is glitch-free and changes exactly
//   on the state boundary.
// -----------------------------------------------------------------------------
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned READ_WAIT_CYCLES   = 2,  // 1..15
    parameter int unsigned WRITE_PULSE_CYCLES = 1   // 1..15
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic [31:0]                address_i,
    input  logic                       read_i,
    input  logic                       write_i,
    input  logic [SRAM_DATA_WIDTH-1:0] data_wr_i,
    input  ByteMask_t                  mask_i,
    output logic                       stall_o,
    output logic [SRAM_DATA_WIDTH-1:0] data_rd_o,
    output logic [SRAM_DATA_WIDTH-1:0] data_rd_2_o,
    output logic [5:0]                 interrupt_o,

    output SramChipAddress_t           sram_address_o,
    output logic [SRAM_DATA_WIDTH-1:0] sram_data_out_o,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_data_in_i,
    output logic                       sram_data_oe_o,
    output ByteMask_t                  sram_be_n_o,
    output logic                       sram_ce_n_o,
    output logic                       sram_oe_n_o,
    output logic                       sram_we_n_o
);

    // Counter value on the final cycle of each timed state.
    localparam logic [3:0] RD_LAST = 4'(READ_WAIT_CYCLES - 1);
    localparam logic [3:0] WR_LAST = 4'(WRITE_PULSE_CYCLES - 1);

    SramState_t                 state_q, state_d;
    logic [3:0]                 wait_cnt_q, wait_cnt_d;
    SramChipAddress_t           addr_q, addr_d;
    logic [SRAM_DATA_WIDTH-1:0] dout_q, dout_d;
    ByteMask_t                  wr_be_n_q, wr_be_n_d;
    logic [SRAM_DATA_WIDTH-1:0] data_rd_q, data_rd_d;
    ByteMask_t                  be_n_q, be_n_d;
    logic                       ce_n_q, ce_n_d;
    logic                       oe_n_q, oe_n_d;
    logic                       we_n_q, we_n_d;
    logic                       data_oe_q, data_oe_d;

    // -------------------------------------------------------------------------
    // State register and all registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            dout_q     <= '0;
            wr_be_n_q  <= BYTE_MASK_ALL;
            data_rd_q  <= '0;
            be_n_q     <= BYTE_MASK_ALL;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            data_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            wr_be_n_q  <= wr_be_n_d;
            data_rd_q  <= data_rd_d;
            be_n_q     <= be_n_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            data_oe_q  <= data_oe_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state, latches and next-cycle strobe values
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        wr_be_n_d = wr_be_n_q;
        data_rd_d = data_rd_q;

        unique case (state_q)
            ST_IDLE: begin
                // Write wins over read; a write with no enabled bytes
                // completes without touching the chip.
                if (write_i) begin
                    if (mask_i != BYTE_MASK_NONE) begin
                        addr_d    = word_addr(address_i);
                        dout_d    = data_wr_i;
                        wr_be_n_d = ~mask_i;
                        state_d   = ST_WR_SETUP;
                    end else begin
                        state_d   = ST_DONE;
                    end
                end else if (read_i) begin
                    addr_d  = word_addr(address_i);
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (wait_cnt_q == RD_LAST) begin
                    data_rd_d = sram_data_in_i;
                    state_d   = ST_DONE;
                end
            end
            ST_WR_SETUP: state_d = ST_WR_PULSE;
            ST_WR_PULSE: begin
                if (wait_cnt_q == WR_LAST) begin
                    state_d = ST_WR_HOLD;
                end
            end
            ST_WR_HOLD:  state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        // Counter restarts from zero on every state entry.
        wait_cnt_d = (state_d != state_q) ? 4'd0 : wait_cnt_q + 4'd1;

        // Strobes for the cycle the FSM is about to enter. WE_n only falls
        // in WR_PULSE, one cycle after CE_n/address/data were set up in
        // WR_SETUP; the data driver is never enabled during a read.
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        be_n_d    = BYTE_MASK_ALL;
        data_oe_d = 1'b0;

        unique case (state_d)
            ST_RD_WAIT: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = BYTE_MASK_NONE;
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                ce_n_d    = 1'b0;
                be_n_d    = wr_be_n_d;
                data_oe_d = 1'b1;
            end
            ST_WR_PULSE: begin
                ce_n_d    = 1'b0;
                we_n_d    = 1'b0;
                be_n_d    = wr_be_n_d;
                data_oe_d = 1'b1;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // stall drops in DONE, or as soon as the master withdraws its request.
    assign stall_o = rst_n & (read_i | write_i) & (state_q != ST_DONE);

    assign data_rd_o       = data_rd_q;
    assign data_rd_2_o     = '0;
    assign interrupt_o     = '0;
    assign sram_address_o  = addr_q;
    assign sram_data_out_o = dout_q;
    assign sram_data_oe_o  = data_oe_q;
    assign sram_be_n_o     = be_n_q;
    assign sram_ce_n_o     = ce_n_q;
    assign sram_oe_n_o     = oe_n_q;
    assign sram_we_n_o     = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
//   Directed and randomized bus transactions against sram_controller with a
//   behavioural SRAM chip attached. A word-array reference model predicts
//   read data and per-transaction latency/strobe counts.
// -----------------------------------------------------------------------------
module tb_sram_controller;
    import sram_controller_pkg::*;

    localparam int RWC = 2;
    localparam int WPC = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] data_wr = '0;
    logic [3:0]  mask = '0;
    logic        stall;
    logic [31:0] data_rd, data_rd_2;
    logic [5:0]  interrupt;
    logic [19:0] sram_address;
    logic [31:0] sram_data_out;
    logic [31:0] sram_data_in;
    logic        sram_data_oe;
    logic [3:0]  sram_be_n;
    logic        sram_ce_n, sram_oe_n, sram_we_n;

    int n_checks = 0;
    int n_errors = 0;

    bit [31:0] chip_mem [64];   // behavioural SRAM chip
    bit [31:0] ref_mem  [64];   // reference model of memory contents

    always #5 clk = ~clk;

    sram_controller #(
        .READ_WAIT_CYCLES  (RWC),
        .WRITE_PULSE_CYCLES(WPC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .address_i      (address),
        .read_i         (read),
        .write_i        (write),
        .data_wr_i      (data_wr),
        .mask_i         (mask),
        .stall_o        (stall),
        .data_rd_o      (data_rd),
        .data_rd_2_o    (data_rd_2),
        .interrupt_o    (interrupt),
        .sram_address_o (sram_address),
        .sram_data_out_o(sram_data_out),
        .sram_data_in_i (sram_data_in),
        .sram_data_oe_o (sram_data_oe),
        .sram_be_n_o    (sram_be_n),
        .sram_ce_n_o    (sram_ce_n),
        .sram_oe_n_o    (sram_oe_n),
        .sram_we_n_o    (sram_we_n)
    );

    // SRAM chip: drives data while selected for read, writes enabled bytes
    // while CE_n and WE_n are both low.
    always_comb begin
        sram_data_in = 32'hA5A5_5A5A;
        if (!sram_ce_n && !sram_oe_n) sram_data_in = chip_mem[sram_address[5:0]];
    end

    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b])
                    chip_mem[sram_address[5:0]][8*b +: 8] <= sram_data_out[8*b +: 8];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus transaction. Inputs are driven at a falling edge (cycle 0) and
    // outputs sampled at each later falling edge until stall drops.
    task automatic do_op(input bit is_wr, input bit both, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] msk, input bit perturb);
        logic [5:0]  idx      = addr[7:2];
        logic [19:0] exp_word = addr[21:2];
        logic [31:0] exp_rd   = ref_mem[idx];
        int lat_exp;
        int lat      = -1;
        int ce_cnt   = 0;
        int oe_cnt   = 0;
        int we_cnt   = 0;
        int doe_cnt  = 0;
        int first_we = -1;
        int bad_ov   = 0;
        int be_bad   = 0;
        int adr_bad  = 0;
        int dat_bad  = 0;
        logic [31:0] got_rd = '0;

        if (!is_wr)                lat_exp = RWC + 1;
        else if (msk == 4'b0000)   lat_exp = 1;
        else                       lat_exp = WPC + 3;

        @(negedge clk);
        address = addr; data_wr = wdata; mask = msk;
        write = is_wr; read = !is_wr || both;
        #1;
        check_eq("stall_c0", {31'b0, stall}, 32'd1);

        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            if (!sram_ce_n)   ce_cnt++;
            if (!sram_oe_n) begin
                oe_cnt++;
                if (sram_address != exp_word) adr_bad++;
            end
            if (sram_data_oe) doe_cnt++;
            if (sram_data_oe && !sram_oe_n) bad_ov++;
            if (!sram_we_n) begin
                we_cnt++;
                if (first_we < 0) first_we = k;
                if (sram_be_n != ~msk)       be_bad++;
                if (sram_address != exp_word) adr_bad++;
                if (sram_data_out != wdata)  dat_bad++;
            end
            if (!stall) begin
                lat    = k;
                got_rd = data_rd;
            end else if (perturb && k == 1) begin
                address = $urandom; data_wr = $urandom; mask = 4'($urandom);
            end
        end
        read = 1'b0; write = 1'b0;

        check_eq("latency", lat, lat_exp);
        check_eq("oe_overlap", bad_ov, 0);
        check_eq("addr_bad", adr_bad, 0);
        if (!is_wr) begin
            check_eq("rd_data", got_rd, exp_rd);
            check_eq("rd_ce_cnt", ce_cnt, RWC);
            check_eq("rd_oe_cnt", oe_cnt, RWC);
            check_eq("rd_we_cnt", we_cnt, 0);
        end else if (msk == 4'b0000) begin
            check_eq("nomask_ce_cnt", ce_cnt, 0);
            check_eq("nomask_doe_cnt", doe_cnt, 0);
        end else begin
            check_eq("wr_we_cnt", we_cnt, WPC);
            check_eq("wr_first_we", first_we, 2);
            check_eq("wr_doe_cnt", doe_cnt, WPC + 2);
            check_eq("wr_ce_cnt", ce_cnt, WPC + 2);
            check_eq("wr_oe_cnt", oe_cnt, 0);
            check_eq("wr_be_bad", be_bad, 0);
            check_eq("wr_dat_bad", dat_bad, 0);
            for (int b = 0; b < 4; b++)
                if (msk[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
        $display("op %s addr=%h wdata=%h mask=%b both=%0d pert=%0d lat=%0d rd=%h",
                 is_wr ? "WR" : "RD", addr, wdata, msk, both, perturb, lat, got_rd);
    endtask

    initial begin
        // Reset held with a read pending.
        rst_n = 1'b0; read = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_stall", {31'b0, stall}, 32'd0);
        check_eq("rst_ce_n", {31'b0, sram_ce_n}, 32'd1);
        check_eq("rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
        check_eq("rst_we_n", {31'b0, sram_we_n}, 32'd1);
        check_eq("rst_be_n", {28'b0, sram_be_n}, 32'hF);
        check_eq("rst_data_oe", {31'b0, sram_data_oe}, 32'd0);
        check_eq("rst_data_rd", data_rd, 32'd0);
        check_eq("rst_addr", {12'b0, sram_address}, 32'd0);
        read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn reset released");

        // Directed transactions.
        do_op(1'b1, 1'b0, {RAM_PREFIX, 24'h000010}, 32'hDEADBEEF, 4'hF, 1'b0);
        check_eq("wr_sram_addr", {12'b0, sram_address}, 32'h4);
        do_op(1'b0, 1'b0, {RAM_PREFIX, 24'h000010}, 32'h0, 4'hF, 1'b0);
        do_op(1'b1, 1'b0, {RAM_PREFIX, 24'h000010}, 32'h12345678, 4'b0011, 1'b0);
        do_op(1'b0, 1'b0, {RAM_PREFIX, 24'h000010}, 32'h0, 4'hF, 1'b0);
        do_op(1'b1, 1'b0, {RAM_PREFIX, 24'h000014}, 32'hCAFEF00D, 4'b0000, 1'b0);
        do_op(1'b0, 1'b0, {RAM_PREFIX, 24'h000014}, 32'h0, 4'hF, 1'b0);
        do_op(1'b1, 1'b1, {RAM_PREFIX, 24'h000020}, 32'h0BADCAFE, 4'hF, 1'b1);
        do_op(1'b0, 1'b0, {RAM_PREFIX, 24'h000020}, 32'h0, 4'hF, 1'b0);

        // Reset asserted during the write pulse.
        @(negedge clk);
        address = 32'h40; data_wr = 32'h55AA55AA; mask = 4'hF; write = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("pre_rst_we_n", {31'b0, sram_we_n}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_we_n", {31'b0, sram_we_n}, 32'd1);
        check_eq("midrst_ce_n", {31'b0, sram_ce_n}, 32'd1);
        check_eq("midrst_data_oe", {31'b0, sram_data_oe}, 32'd0);
        check_eq("midrst_stall", {31'b0, stall}, 32'd0);
        write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn reset during write pulse released");
        do_op(1'b0, 1'b0, {RAM_PREFIX, 24'h000010}, 32'h0, 4'hF, 1'b0);
        // The interrupted word is undefined; rewrite before reading it.
        do_op(1'b1, 1'b0, 32'h40, 32'h13579BDF, 4'hF, 1'b0);
        do_op(1'b0, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            logic [5:0]  widx = 6'($urandom);
            logic [31:0] a    = {10'($urandom), 14'b0, widx, 2'($urandom)};
            int          op   = $urandom_range(0, 2);
            logic [3:0]  m    = (op == 1) ? 4'hF : 4'($urandom);
            bit          bth  = ($urandom_range(0, 3) == 0);
            bit          prt  = 1'($urandom);
            if (op == 0) do_op(1'b0, 1'b0, a, 32'h0, 4'hF, prt);
            else         do_op(1'b1, bth, a, $urandom, m, prt);
        end

        check_eq("data_rd_2", data_rd_2, 32'd0);
        check_eq("interrupt", {26'b0, interrupt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
